video_linemult: RTL
===================

// Module: video_linemult
// PURPOSE
//  Parametrised line multiplier: next generation of the VGA scandoubler. Captures one TV-rate
//  line of palette-applied colour into a ping-pong line buffer and replays it 1..4 times at
//  the output line rate, with optional scanline dimming on odd replays. Sits between the
//  palette/border mixer and the TV/VGA output mux of the video top level.
// PARAMETERS
//  PIX_W    6    colour width; packed as NCOMP fields of CMP_W bits (GgRrBb)
//  CMP_W    2    bits per colour component; PIX_W must equal NCOMP*CMP_W
//  LINE_LEN 896  max stored pixels per input line
//  ADDR_W   10   buffer address width; 2**ADDR_W >= LINE_LEN
// PORTS
//  clk           in   1      28 MHz system clock
//  rst_n         in   1      async active-low reset
//  mult          in   2      replay count minus 1: 0=1x 1=2x 2=3x 3=4x; sampled at scanout_start
//  dim_ena       in   1      halve components on odd replays; sampled at scanout_start
//  scanin_start  in   1      1-clk strobe: start of input line
//  pix_in_stb    in   1      input pixel valid
//  pix_in        in   PIX_W  input pixel
//  scanout_start in   1      1-clk strobe: start of output line
//  pix_out_stb   in   1      output pixel request
//  pix_out       out  PIX_W  output pixel (registered)
//  rep_idx       out  2      replay index of current output line
//  underrun      out  1      sticky: output line requested beyond mult replays
//  overflow      out  1      sticky: input pixels beyond LINE_LEN dropped
//  clr_flags     in   1      clears underrun/overflow (lower priority than setting events)
// BEHAVIOUR
//  Reset: pix_out=0, rep_idx=0, flags=0, wr_addr=rd_addr=0, wr_bank=0, both banks invalid.
//  Write side: scanin_start -> length of current bank stored, bank marked valid, wr_bank
//   toggles, wr_addr=0. Each pix_in_stb writes pix_in at wr_addr, wr_addr++; at LINE_LEN
//   wr_addr holds, further pixels are dropped and overflow set. A pixel with the same
//   clk as scanin_start goes to address 0 of the new bank.
//  Read side: scanout_start -> if a bank completed since the last selection: rd_bank=that
//   bank, rep_idx=0, mult/dim_ena latched; else if rep_idx<mult_latched: rep_idx++;
//   else rep_idx holds, underrun set, line replayed again. rd_addr=0.
//  Simultaneous scanin_start+scanout_start: write-side swap first; the read side takes
//   the line just completed.
//  Each pix_out_stb reads rd_addr, rd_addr++ (saturates at 2**ADDR_W-1); pix_out valid
//   2 clks after stb (RAM read + output reg). rd_addr >= stored length, or no valid bank:
//   pix_out=0 (blank).
//  Dimming: dim_ena latched and rep_idx[0]=1 -> each component c becomes c>>1.
//  Reading the bank being written is impossible by construction (ping-pong).
//  Reset mid-line: all state returns to reset values; output stays blank until the first
//   full input line completes.
// STRUCTURE
//  Shared package video_pkg: MULT_1X..MULT_4X encodings, CMP_W, default PIX_W/LINE_LEN.
//  Sub-module video_linemult_bank: 2*2**ADDR_W x PIX_W simple dual-port RAM, bank bit
//   is the address MSB, sync write, registered read, no reset on array.
//  Top: write counter/bank FSM, read counter/replay FSM (IDLE, REPLAY, UNDERRUN), dimming
//   and blanking on the output register.
// TESTING
//  1. Reset, mult=1, 896 ramp pixels (value=addr%64), then 2 scanout lines -> both lines
//     replay 0..63 ramp; rep_idx 0 then 1; flags stay 0.
//  2. mult=3, dim_ena=1, line of 6'h3F -> 4 output lines: 3F,15,3F,15; rep_idx 0..3.
//  3. mult=0, 3 scanout_start per scanin_start -> lines 2,3 replay; underrun=1;
//     clr_flags -> 0.
//  4. 900 pix_in_stb in one line -> first 896 stored, overflow=1; read 900 -> last 4 = 0.
//  5. Coincident scanin_start+scanout_start -> output takes just-finished line, rep_idx=0.
//  6. rst_n low mid-line during replay -> pix_out=0 next clk; blank until a full line in.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video definitions: component geometry, default line geometry, replay encodings.
package video_pkg;

    localparam int unsigned VID_CMP_W    = 2;
    localparam int unsigned VID_NCOMP    = 3;
    localparam int unsigned PIX_W_DEF    = VID_NCOMP * VID_CMP_W;
    localparam int unsigned LINE_LEN_DEF = 896;
    localparam int unsigned ADDR_W_DEF   = 10;

    // Replay count minus one, as carried on the mult input
    typedef enum logic [1:0] {
        MULT_1X = 2'd0,
        MULT_2X = 2'd1,
        MULT_3X = 2'd2,
        MULT_4X = 2'd3
    } mult_e;

    // Read-side replay state
    typedef enum logic [1:0] {
        RD_IDLE     = 2'd0,
        RD_REPLAY   = 2'd1,
        RD_UNDERRUN = 2'd2
    } rd_state_e;

    // Per-read attributes travelling alongside the RAM access
    typedef struct packed {
        logic stb;
        logic blank;
        logic dim;
    } rd_tag_t;

endpackage

// File: rtl/video_linemult_bank.sv
// Ping-pong line store: simple dual-port RAM, bank bit is the address MSB.
module video_linemult_bank #(
    parameter int unsigned PIX_W  = 6,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W:0]   wr_addr_i,
    input  logic [PIX_W-1:0]  wr_data_i,
    input  logic [ADDR_W:0]   rd_addr_i,
    output logic [PIX_W-1:0]  rd_data_o
);

    localparam int unsigned DEPTH = 2 * (2 ** ADDR_W);

    logic [PIX_W-1:0] mem_q [0:DEPTH-1];

    // Synchronous write, registered read; array contents are never reset
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/video_linemult.sv
// Line multiplier: captures one input line per bank and replays it 1..4 times with optional dimming.
module video_linemult
    import video_pkg::*;
#(
    parameter int unsigned PIX_W    = PIX_W_DEF,
    parameter int unsigned CMP_W    = VID_CMP_W,
    parameter int unsigned LINE_LEN = LINE_LEN_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mult,
    input  logic              dim_ena,
    input  logic              scanin_start,
    input  logic              pix_in_stb,
    input  logic [PIX_W-1:0]  pix_in,
    input  logic              scanout_start,
    input  logic              pix_out_stb,
    output logic [PIX_W-1:0]  pix_out,
    output logic [1:0]        rep_idx,
    output logic              underrun,
    output logic              overflow,
    input  logic              clr_flags
);

    localparam int unsigned   NCOMP       = PIX_W / CMP_W;
    localparam int unsigned   CNT_W       = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  LEN_MAX     = CNT_W'(LINE_LEN);
    localparam logic [ADDR_W-1:0] RD_ADDR_MAX = '1;

    // Write side
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic [1:0]       bank_valid_q, bank_valid_d;
    logic             pend_q, pend_d;
    logic             pend_bank_q, pend_bank_d;
    logic [CNT_W-1:0] pend_len_q, pend_len_d;
    logic             overflow_q, overflow_d;
    logic             ovf_set_c;
    logic             wr_en_c;
    logic [ADDR_W:0]  wr_ram_addr_c;

    // Read side
    rd_state_e        state_q;
    logic             rd_bank_q;
    logic [CNT_W-1:0] rd_len_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [1:0]       rep_q;
    mult_e            mult_q;
    logic             dim_q;
    logic             underrun_q;
    logic             sel_c;
    logic             sel_bank_c;
    logic [CNT_W-1:0] sel_len_c;
    logic             und_set_c;

    // Output pipeline
    rd_tag_t          tag_c, tag_q;
    logic [PIX_W-1:0] rd_data;
    logic [PIX_W-1:0] dimmed_c;
    logic [PIX_W-1:0] pix_out_q;

    // Write counter, bank swap and completed-line hand-off
    always_comb begin
        wr_cnt_d      = wr_cnt_q;
        wr_bank_d     = wr_bank_q;
        bank_valid_d  = bank_valid_q;
        pend_d        = pend_q;
        pend_bank_d   = pend_bank_q;
        pend_len_d    = pend_len_q;
        overflow_d    = overflow_q;
        ovf_set_c     = 1'b0;
        wr_en_c       = 1'b0;
        wr_ram_addr_c = {wr_bank_q, wr_cnt_q[ADDR_W-1:0]};
        if (scanin_start) begin
            bank_valid_d[wr_bank_q] = 1'b1;
            pend_d      = 1'b1;
            pend_bank_d = wr_bank_q;
            pend_len_d  = wr_cnt_q;
            wr_bank_d   = ~wr_bank_q;
            wr_cnt_d    = '0;
            if (pix_in_stb) begin
                wr_en_c       = 1'b1;
                wr_ram_addr_c = {~wr_bank_q, {ADDR_W{1'b0}}};
                wr_cnt_d      = CNT_W'(1);
            end
        end else if (pix_in_stb) begin
            if (wr_cnt_q < LEN_MAX) begin
                wr_en_c  = 1'b1;
                wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end else begin
                ovf_set_c = 1'b1;
            end
        end
        // Any output line start consumes the pending line (or finds none)
        if (scanout_start) begin
            pend_d = 1'b0;
        end
        if (ovf_set_c) begin
            overflow_d = 1'b1;
        end else if (clr_flags) begin
            overflow_d = 1'b0;
        end
    end

    // Write-side state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q     <= '0;
            wr_bank_q    <= 1'b0;
            bank_valid_q <= '0;
            pend_q       <= 1'b0;
            pend_bank_q  <= 1'b0;
            pend_len_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            wr_cnt_q     <= wr_cnt_d;
            wr_bank_q    <= wr_bank_d;
            bank_valid_q <= bank_valid_d;
            pend_q       <= pend_d;
            pend_bank_q  <= pend_bank_d;
            pend_len_q   <= pend_len_d;
            overflow_q   <= overflow_d;
        end
    end

    // A line completing in this very clock wins over an older pending one
    assign sel_c      = pend_q | scanin_start;
    assign sel_bank_c = scanin_start ? wr_bank_q : pend_bank_q;
    assign sel_len_c  = scanin_start ? wr_cnt_q  : pend_len_q;
    assign und_set_c  = scanout_start & ~sel_c & (state_q != RD_IDLE) & (rep_q >= mult_q);

    // Replay FSM and read address counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RD_IDLE;
            rd_bank_q  <= 1'b0;
            rd_len_q   <= '0;
            rd_addr_q  <= '0;
            rep_q      <= '0;
            mult_q     <= MULT_1X;
            dim_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (scanout_start) begin
                rd_addr_q <= '0;
                if (sel_c) begin
                    state_q   <= RD_REPLAY;
                    rd_bank_q <= sel_bank_c;
                    rd_len_q  <= sel_len_c;
                    rep_q     <= '0;
                    mult_q    <= mult_e'(mult);
                    dim_q     <= dim_ena;
                end else if (state_q != RD_IDLE) begin
                    if (rep_q < mult_q) begin
                        rep_q   <= rep_q + 2'd1;
                        state_q <= RD_REPLAY;
                    end else begin
                        state_q <= RD_UNDERRUN;
                    end
                end
            end else if (pix_out_stb && (rd_addr_q != RD_ADDR_MAX)) begin
                rd_addr_q <= rd_addr_q + ADDR_W'(1);
            end
            if (und_set_c) begin
                underrun_q <= 1'b1;
            end else if (clr_flags) begin
                underrun_q <= 1'b0;
            end
        end
    end

    video_linemult_bank #(
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk       (clk),
        .wr_en_i   (wr_en_c),
        .wr_addr_i (wr_ram_addr_c),
        .wr_data_i (pix_in),
        .rd_addr_i ({rd_bank_q, rd_addr_q}),
        .rd_data_o (rd_data)
    );

    // Blank/dim decision taken with the read request, applied when data returns
    always_comb begin
        tag_c       = '0;
        tag_c.stb   = pix_out_stb & ~scanout_start;
        tag_c.blank = ~bank_valid_q[rd_bank_q] | ({1'b0, rd_addr_q} >= rd_len_q);
        tag_c.dim   = dim_q & rep_q[0];
    end

    // Per-component halving for scanline dimming
    always_comb begin
        dimmed_c = '0;
        for (int unsigned k = 0; k < NCOMP; k++) begin
            dimmed_c[k*CMP_W +: CMP_W] = rd_data[k*CMP_W +: CMP_W] >> 1;
        end
    end

    // Read tag stage and output pixel register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q     <= '0;
            pix_out_q <= '0;
        end else begin
            tag_q <= tag_c;
            if (tag_q.stb) begin
                pix_out_q <= tag_q.blank ? '0 : (tag_q.dim ? dimmed_c : rd_data);
            end
        end
    end

    assign pix_out  = pix_out_q;
    assign rep_idx  = rep_q;
    assign underrun = underrun_q;
    assign overflow = overflow_q;

endmodule
